// File: rtl/data_path_if.sv
//==============================================================================
// Module  : data_path_if
// Strobe, select and memory bus bundle between control unit/memory and datapath.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface data_path_if;
  // Register strobes
  logic       IR_LOAD;
  logic       MAR_LOAD;
  logic       PC_LOAD;
  logic       PC_INC;
  logic       A_LOAD;
  logic       B_LOAD;
  logic       CCR_LOAD;

  // Selects
  logic [2:0] ALU_SEL;
  logic [1:0] TO_MEMORY_BUS_SEL;
  logic [1:0] FROM_MEMORY_BUS_SEL;

  // Memory side and status back to the control unit
  logic [7:0] from_memory;
  logic [7:0] address;
  logic [7:0] to_memory;
  logic [7:0] IR;
  logic [3:0] CCR;

  modport master (
    output IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD,
    output ALU_SEL, TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL, from_memory,
    input  address, to_memory, IR, CCR
  );

  modport slave (
    input  IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD,
    input  ALU_SEL, TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL, from_memory,
    output address, to_memory, IR, CCR
  );
endinterface

`default_nettype wire

// File: rtl/data_path.sv
//==============================================================================
// Module  : data_path
// 8-bit CPU datapath: IR, MAR, PC, A, B, CCR registers, BUS1/BUS2 muxes and ALU.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module data_path (
  input  logic       clk,
  input  logic       reset,
  data_path_if.slave bus
);

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_INC = 3'b100;
  localparam logic [2:0] c_ALU_DEC = 3'b101;

  localparam logic [1:0] c_BUS1_PC   = 2'b00;
  localparam logic [1:0] c_BUS1_A    = 2'b01;
  localparam logic [1:0] c_BUS1_B    = 2'b10;

  localparam logic [1:0] c_BUS2_ALU  = 2'b00;
  localparam logic [1:0] c_BUS2_BUS1 = 2'b01;
  localparam logic [1:0] c_BUS2_MEM  = 2'b10;

  logic [7:0] r_ir;
  logic [7:0] r_mar;
  logic [7:0] r_pc;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [3:0] r_ccr;

  logic [7:0] w_bus1;
  logic [7:0] w_bus2;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_alu_result;
  logic       w_alu_v;
  logic       w_alu_c;
  logic [3:0] w_alu_flags;

  always_comb begin
    case (bus.TO_MEMORY_BUS_SEL)
      c_BUS1_PC: w_bus1 = r_pc;
      c_BUS1_A:  w_bus1 = r_a;
      c_BUS1_B:  w_bus1 = r_b;
      default:   w_bus1 = 8'h00;
    endcase
  end

  // Ninth bit of the 9-bit add/subtract is carry-out / borrow respectively.
  assign w_sum  = {1'b0, w_bus1} + {1'b0, r_b};
  assign w_diff = {1'b0, w_bus1} - {1'b0, r_b};

  always_comb begin
    w_alu_result = w_bus1;
    w_alu_v      = 1'b0;
    w_alu_c      = 1'b0;
    case (bus.ALU_SEL)
      c_ALU_ADD: begin
        w_alu_result = w_sum[7:0];
        w_alu_c      = w_sum[8];
        w_alu_v      = (w_bus1[7] == r_b[7]) && (w_sum[7] != w_bus1[7]);
      end
      c_ALU_SUB: begin
        w_alu_result = w_diff[7:0];
        w_alu_c      = w_diff[8];
        w_alu_v      = (w_bus1[7] != r_b[7]) && (w_diff[7] != w_bus1[7]);
      end
      c_ALU_AND: w_alu_result = w_bus1 & r_b;
      c_ALU_OR:  w_alu_result = w_bus1 | r_b;
      c_ALU_INC: begin
        w_alu_result = w_bus1 + 8'd1;
        w_alu_c      = (w_bus1 == 8'hFF);
        w_alu_v      = (w_bus1 == 8'h7F);
      end
      c_ALU_DEC: begin
        w_alu_result = w_bus1 - 8'd1;
        w_alu_c      = (w_bus1 == 8'h00);
        w_alu_v      = (w_bus1 == 8'h80);
      end
      default: begin
        w_alu_result = w_bus1;
        w_alu_v      = 1'b0;
        w_alu_c      = 1'b0;
      end
    endcase
  end

  assign w_alu_flags = {w_alu_result[7], (w_alu_result == 8'h00), w_alu_v, w_alu_c};

  always_comb begin
    case (bus.FROM_MEMORY_BUS_SEL)
      c_BUS2_ALU:  w_bus2 = w_alu_result;
      c_BUS2_BUS1: w_bus2 = w_bus1;
      c_BUS2_MEM:  w_bus2 = bus.from_memory;
      default:     w_bus2 = 8'h00;
    endcase
  end

  // Every target loads the same BUS2 value independently; CCR only sees ALU flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir  <= 8'h00;
      r_mar <= 8'h00;
      r_pc  <= 8'h00;
      r_a   <= 8'h00;
      r_b   <= 8'h00;
      r_ccr <= 4'h0;
    end else begin
      if (bus.IR_LOAD)  r_ir  <= w_bus2;
      if (bus.MAR_LOAD) r_mar <= w_bus2;
      if (bus.PC_LOAD)
        r_pc <= w_bus2;
      else if (bus.PC_INC)
        r_pc <= r_pc + 8'd1;
      if (bus.A_LOAD)   r_a   <= w_bus2;
      if (bus.B_LOAD)   r_b   <= w_bus2;
      if (bus.CCR_LOAD) r_ccr <= w_alu_flags;
    end
  end

  assign bus.address   = r_mar;
  assign bus.to_memory = w_bus1;
  assign bus.IR        = r_ir;
  assign bus.CCR       = r_ccr;

endmodule

`default_nettype wire

// File: tb/tb_data_path.sv
//==============================================================================
// Module  : tb_data_path
// Self-checking bench for data_path: vector table, corner sequences, random run.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_path;

  localparam logic [6:0] S_IR  = 7'b1000000;
  localparam logic [6:0] S_MAR = 7'b0100000;
  localparam logic [6:0] S_PCL = 7'b0010000;
  localparam logic [6:0] S_PCI = 7'b0001000;
  localparam logic [6:0] S_A   = 7'b0000100;
  localparam logic [6:0] S_B   = 7'b0000010;
  localparam logic [6:0] S_CCR = 7'b0000001;

  typedef struct {
    logic [6:0] st;
    logic [2:0] alu;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [7:0] mem;
    logic [7:0] e_ir;
    logic [7:0] e_mar;
    logic [7:0] e_pc;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [3:0] e_ccr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  data_path_if bus ();

  data_path dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_ir, m_mar, m_pc, m_a, m_b;
  logic [3:0] m_ccr;
  logic [7:0] mem_img [256];
  vec_t       vecs [23];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] st, input logic [2:0] alu,
                       input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] mem);
    {bus.IR_LOAD, bus.MAR_LOAD, bus.PC_LOAD, bus.PC_INC,
     bus.A_LOAD, bus.B_LOAD, bus.CCR_LOAD} = st;
    bus.ALU_SEL             = alu;
    bus.TO_MEMORY_BUS_SEL   = s1;
    bus.FROM_MEMORY_BUS_SEL = s2;
    bus.from_memory         = mem;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // PC, A and B are only visible through BUS1, so they are peeked with all strobes low.
  task automatic check_all(input string tag, input logic [7:0] e_ir, input logic [7:0] e_mar,
                           input logic [7:0] e_pc, input logic [7:0] e_a, input logic [7:0] e_b,
                           input logic [3:0] e_ccr);
    check({tag, " IR"}, bus.IR, e_ir);
    check({tag, " address"}, bus.address, e_mar);
    check({tag, " CCR"}, {4'h0, bus.CCR}, {4'h0, e_ccr});
    drive(7'd0, 3'd0, 2'b00, 2'b00, 8'h00);
    #1 check({tag, " PC"}, bus.to_memory, e_pc);
    bus.TO_MEMORY_BUS_SEL = 2'b01;
    #1 check({tag, " A"}, bus.to_memory, e_a);
    bus.TO_MEMORY_BUS_SEL = 2'b10;
    #1 check({tag, " B"}, bus.to_memory, e_b);
  endtask

  function automatic logic [11:0] ref_alu(input int op, input int x, input int y);
    int sx, sy, full, sres, r;
    logic n, z, v, c;
    logic [7:0] r8;
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    v = 1'b0;
    c = 1'b0;
    sres = 0;
    case (op)
      0: begin full = x + y; c = (full > 255); sres = sx + sy; v = (sres > 127) || (sres < -128); end
      1: begin full = x - y; c = (x < y);      sres = sx - sy; v = (sres > 127) || (sres < -128); end
      2: full = x & y;
      3: full = x | y;
      4: begin full = x + 1; c = (x == 255); sres = sx + 1; v = (sres > 127); end
      5: begin full = x - 1; c = (x == 0);   sres = sx - 1; v = (sres < -128); end
      default: full = x;
    endcase
    r  = ((full % 256) + 256) % 256;
    r8 = 8'(r);
    n  = (r > 127);
    z  = (r == 0);
    return {r8, n, z, v, c};
  endfunction

  task automatic cycle(input string tag, input logic [6:0] st, input logic [2:0] alu,
                       input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] mem);
    logic [7:0]  x, b2;
    logic [11:0] res;
    case (s1)
      2'd0: x = m_pc;
      2'd1: x = m_a;
      2'd2: x = m_b;
      default: x = 8'h00;
    endcase
    res = ref_alu(int'(alu), int'(x), int'(m_b));
    case (s2)
      2'd0: b2 = res[11:4];
      2'd1: b2 = x;
      2'd2: b2 = mem;
      default: b2 = 8'h00;
    endcase
    if (st[6]) m_ir  = b2;
    if (st[5]) m_mar = b2;
    if (st[4]) m_pc = b2;
    else if (st[3]) m_pc = m_pc + 8'd1;
    if (st[2]) m_a   = b2;
    if (st[1]) m_b   = b2;
    if (st[0]) m_ccr = res[3:0];
    drive(st, alu, s1, s2, mem);
    step();
    check_all(tag, m_ir, m_mar, m_pc, m_a, m_b, m_ccr);
  endtask

  function automatic vec_t mk(input logic [6:0] st, input logic [2:0] alu, input logic [1:0] s1,
                              input logic [1:0] s2, input logic [7:0] mem,
                              input logic [7:0] ir, input logic [7:0] mar, input logic [7:0] pc,
                              input logic [7:0] a, input logic [7:0] b, input logic [3:0] ccr);
    vec_t v;
    v.st = st; v.alu = alu; v.s1 = s1; v.s2 = s2; v.mem = mem;
    v.e_ir = ir; v.e_mar = mar; v.e_pc = pc; v.e_a = a; v.e_b = b; v.e_ccr = ccr;
    return v;
  endfunction

  initial begin
    //                st             alu  s1 s2 mem    IR     MAR    PC     A      B      CCR
    vecs[0]  = mk(S_PCL,           0, 0, 2, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 4'h0);
    vecs[1]  = mk(S_MAR,           0, 0, 1, 8'hAA, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00, 4'h0);
    vecs[2]  = mk(S_PCI,           0, 0, 0, 8'h00, 8'h00, 8'h03, 8'h04, 8'h00, 8'h00, 4'h0);
    vecs[3]  = mk(S_IR,            0, 0, 2, 8'h10, 8'h10, 8'h03, 8'h04, 8'h00, 8'h00, 4'h0);
    vecs[4]  = mk(S_PCL,           0, 0, 2, 8'hFF, 8'h10, 8'h03, 8'hFF, 8'h00, 8'h00, 4'h0);
    vecs[5]  = mk(S_PCI,           0, 0, 0, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00, 4'h0);
    vecs[6]  = mk(S_PCL | S_PCI,   0, 0, 2, 8'h42, 8'h10, 8'h03, 8'h42, 8'h00, 8'h00, 4'h0);
    vecs[7]  = mk(S_A,             0, 0, 2, 8'h7F, 8'h10, 8'h03, 8'h42, 8'h7F, 8'h00, 4'h0);
    vecs[8]  = mk(S_B,             0, 0, 2, 8'h01, 8'h10, 8'h03, 8'h42, 8'h7F, 8'h01, 4'h0);
    vecs[9]  = mk(S_A | S_CCR,     0, 1, 0, 8'h00, 8'h10, 8'h03, 8'h42, 8'h80, 8'h01, 4'hA);
    vecs[10] = mk(S_A,             0, 0, 2, 8'h00, 8'h10, 8'h03, 8'h42, 8'h00, 8'h01, 4'hA);
    vecs[11] = mk(S_A | S_CCR,     1, 1, 0, 8'h00, 8'h10, 8'h03, 8'h42, 8'hFF, 8'h01, 4'h9);
    vecs[12] = mk(S_B | S_CCR,     5, 2, 0, 8'h00, 8'h10, 8'h03, 8'h42, 8'hFF, 8'h00, 4'h4);
    vecs[13] = mk(S_A,             0, 0, 2, 8'hF0, 8'h10, 8'h03, 8'h42, 8'hF0, 8'h00, 4'h4);
    vecs[14] = mk(S_B,             0, 0, 2, 8'h0F, 8'h10, 8'h03, 8'h42, 8'hF0, 8'h0F, 4'h4);
    vecs[15] = mk(S_A | S_CCR,     3, 1, 0, 8'h00, 8'h10, 8'h03, 8'h42, 8'hFF, 8'h0F, 4'h8);
    vecs[16] = mk(7'd0,            1, 3, 3, 8'h99, 8'h10, 8'h03, 8'h42, 8'hFF, 8'h0F, 4'h8);
    vecs[17] = mk(S_CCR,           4, 0, 0, 8'h00, 8'h10, 8'h03, 8'h42, 8'hFF, 8'h0F, 4'h0);
    vecs[18] = mk(S_IR,            0, 0, 3, 8'h77, 8'h00, 8'h03, 8'h42, 8'hFF, 8'h0F, 4'h0);
    vecs[19] = mk(S_MAR|S_A|S_B,   0, 0, 2, 8'h5C, 8'h00, 8'h5C, 8'h42, 8'h5C, 8'h5C, 4'h0);
    vecs[20] = mk(S_B | S_CCR,     2, 3, 0, 8'h00, 8'h00, 8'h5C, 8'h42, 8'h5C, 8'h00, 4'h4);
    vecs[21] = mk(S_A | S_CCR,     6, 0, 0, 8'h00, 8'h00, 8'h5C, 8'h42, 8'h42, 8'h00, 4'h0);
    vecs[22] = mk(S_PCI | S_CCR,   1, 3, 0, 8'h00, 8'h00, 8'h5C, 8'h43, 8'h42, 8'h00, 4'h4);

    for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
    mem_img[3] = 8'h10;

    // Reset asserted from time zero, before any clock edge.
    reset = 1'b0;
    drive(7'd0, 3'd0, 2'd0, 2'd0, 8'h00);
    #2;
    check_all("por", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all("por hold", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].st, vecs[i].alu, vecs[i].s1, vecs[i].s2, vecs[i].mem);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_mar, vecs[i].e_pc,
                vecs[i].e_a, vecs[i].e_b, vecs[i].e_ccr);
    end

    // Mid-operation reset between edges, with loads pending.
    drive(S_A, 3'd0, 2'd0, 2'd2, 8'h5A);
    step();
    drive(S_PCL, 3'd0, 2'd0, 2'd2, 8'h10);
    step();
    drive(7'd0, 3'd0, 2'd1, 2'd0, 8'h00);
    #1 check("preload A", bus.to_memory, 8'h5A);
    bus.TO_MEMORY_BUS_SEL = 2'd0;
    #1 check("preload PC", bus.to_memory, 8'h10);
    drive(S_A | S_B | S_IR | S_CCR, 3'd0, 2'd0, 2'd2, 8'h77);
    #1 reset = 1'b0;
    #1 check_all("async rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_all("rst release", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    {m_ir, m_mar, m_pc, m_a, m_b} = 40'h0;
    m_ccr = 4'h0;

    // Fetch against a small memory image.
    cycle("ld pc", S_PCL, 3'd0, 2'd0, 2'd2, 8'h03);
    cycle("fetch0", S_MAR, 3'd0, 2'd0, 2'd1, 8'h00);
    cycle("fetch1", S_PCI, 3'd0, 2'd0, 2'd0, mem_img[m_mar]);
    cycle("fetch2", S_IR, 3'd0, 2'd0, 2'd2, mem_img[m_mar]);
    check("fetch IR", bus.IR, 8'h10);
    check("fetch MAR", bus.address, 8'h03);

    // Unknown selects while every strobe is low must leave all registers alone.
    drive(7'd0, 3'bx, 2'bx, 2'bx, 8'hxx);
    step();
    check_all("x sel hold", m_ir, m_mar, m_pc, m_a, m_b, m_ccr);

    // OR then store B to memory.
    cycle("ld A", S_A, 3'd0, 2'd0, 2'd2, 8'hF0);
    cycle("ld B", S_B, 3'd0, 2'd0, 2'd2, 8'h0F);
    cycle("or", S_A | S_CCR, 3'd3, 2'd1, 2'd0, 8'h00);
    check("or CCR", {4'h0, bus.CCR}, 8'h08);
    drive(7'd0, 3'd0, 2'd2, 2'd0, 8'h00);
    #1 check("store to_memory", bus.to_memory, 8'h0F);
    check("store address", bus.address, 8'h03);

    for (int i = 0; i < 400; i++) begin
      logic [6:0] st;
      st = 7'($urandom & $urandom);
      cycle($sformatf("rnd%0d", i), st, 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
